// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite bus encodings and the SRAM slave FSM state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SLV_IDLE,
        SLV_WAIT,
        SLV_DATA,
        SLV_ERR1,
        SLV_ERR2
    } slv_state_e;

    // Output values the slave presents while sitting in a given state.
    function automatic logic slv_ready(slv_state_e s);
        return !(s == SLV_WAIT || s == SLV_ERR1);
    endfunction

    function automatic logic slv_resp(slv_state_e s);
        return (s == SLV_ERR1 || s == SLV_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    endfunction

endpackage

// File: rtl/ahb3lite_wstrb_gen.sv
// Byte-lane write strobes (little-endian) from transfer size and low address bits.
module ahb3lite_wstrb_gen
    import ahb3lite_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    always_comb begin
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE:  strb = 4'b0001 << addr_lo;
            HSIZE_HWORD: strb = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD:  strb = 4'b1111;
            default:     strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word-organised SRAM slave with configurable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W:0] DEPTH_W = (WIDX_W + 1)'(MEM_DEPTH);
    localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES - 1);

    slv_state_e        state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  widx_q;
    logic [1:0]        alo_q;
    logic [2:0]        size_q;
    logic              write_q;

    logic [31:0]       mem [MEM_DEPTH];

    logic [WIDX_W-1:0] haddr_widx;
    logic              req_err;
    logic              accept;
    slv_state_e        acc_state;
    logic              commit;
    logic              load_rd;
    logic [IDX_W-1:0]  rd_idx;
    logic [3:0]        wstrb;
    logic [31:0]       rd_word;
    logic [31:0]       rd_merged;
    logic              unused_inputs;

    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};
    assign dbg_state     = state;
    assign haddr_widx    = HADDR[ADDR_W-1:2];

    assign req_err = ({1'b0, haddr_widx} >= DEPTH_W)
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HWORD) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

    // Handshake: a transfer is taken when HSEL, HREADY and HTRANS[1] are all high
    // at a rising edge while the slave can start a new data phase (IDLE, DATA, ERR2);
    // the data phase completes at the first edge where HREADYOUT is high.
    assign accept = ((state == SLV_IDLE) | (state == SLV_DATA) | (state == SLV_ERR2))
                  & HSEL & HREADY & HTRANS[1];

    assign acc_state = req_err ? SLV_ERR1 : ((WAIT_STATES > 0) ? SLV_WAIT : SLV_DATA);

    assign commit = (state == SLV_DATA) & write_q & ~HRESET;

    assign load_rd = ((state == SLV_WAIT) & (wait_cnt == 4'd0) & ~write_q)
                   | (accept & (acc_state == SLV_DATA) & ~HWRITE);

    ahb3lite_wstrb_gen u_wstrb (
        .size    (size_q),
        .addr_lo (alo_q),
        .strb    (wstrb)
    );

    assign rd_idx  = (state == SLV_WAIT) ? widx_q : HADDR[IDX_W+1:2];
    assign rd_word = mem[rd_idx];

    // A write retiring on the same edge a read to that word is loaded must be visible.
    always_comb begin
        rd_merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (commit && (widx_q == rd_idx) && wstrb[i]) begin
                rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= SLV_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            wait_cnt  <= '0;
            widx_q    <= '0;
            alo_q     <= '0;
            size_q    <= HSIZE_BYTE;
            write_q   <= 1'b0;
        end else begin
            if (accept) begin
                widx_q   <= HADDR[IDX_W+1:2];
                alo_q    <= HADDR[1:0];
                size_q   <= HSIZE;
                write_q  <= HWRITE;
                wait_cnt <= WS_LOAD;
            end
            if (load_rd) begin
                HRDATA <= rd_merged;
            end
            case (state)
                SLV_IDLE, SLV_DATA, SLV_ERR2: begin
                    if (accept) begin
                        state     <= acc_state;
                        HREADYOUT <= slv_ready(acc_state);
                        HRESP     <= slv_resp(acc_state);
                    end else if (state != SLV_IDLE) begin
                        state     <= SLV_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                SLV_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= SLV_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                SLV_ERR1: begin
                    state     <= SLV_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= SLV_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: a zero-wait and a two-wait instance driven by a
// pipelined master, checked against a byte-level memory model and expected-data queue.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        kv;
        logic [31:0] kexp;
    } tx_t;

    logic        clk;
    logic        hreset;
    logic        hsel      [2];
    logic [15:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [3:0]  hprot     [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic        stall     [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [2:0]  dbg       [2];

    logic [31:0] ref_mem [2][256];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q[$];
    tx_t         txq[$];
    int          n_checks;
    int          n_pass;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hready[0] = hreadyout[0] & ~stall[0];
    assign hready[1] = hreadyout[1] & ~stall[1];

    ahb3lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .ADDR_W(16)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .dbg_state(dbg[0])
    );

    ahb3lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2), .ADDR_W(16)) u_dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .dbg_state(dbg[1])
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int ws_of(input int p);
        return (p == 0) ? 0 : 2;
    endfunction

    function automatic logic is_err(input logic [2:0] size, input logic [15:0] addr);
        int a;
        a = int'(addr);
        if (a / 4 >= 256) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if (a % (1 << size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(input int p, input logic [2:0] size,
                                        input logic [15:0] addr, input logic [31:0] wdata);
        int a;
        int ba;
        a = int'(addr);
        for (int b = 0; b < (1 << size); b++) begin
            ba = a + b;
            ref_mem[p][ba / 4][8*(ba % 4) +: 8] = wdata[8*(ba % 4) +: 8];
        end
    endfunction

    function automatic tx_t mk(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [2:0] size, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic kv, input logic [31:0] kexp);
        tx_t t;
        t.sel = sel; t.trans = trans; t.write = write; t.size = size; t.addr = addr;
        t.wdata = wdata; t.stall = 1'b0; t.kv = kv; t.kexp = kexp;
        return t;
    endfunction

    function automatic tx_t rand_tx();
        tx_t t;
        int  r;
        t = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0, $urandom(), 1'b0, 32'h0);
        t.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        t.trans = (r < 2) ? 2'(r) : ((r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ);
        t.write = 1'($urandom_range(0, 1));
        t.size = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r < 5) t.addr = 16'($urandom_range(0, 255) * 4);
        else if (r == 5) t.addr = 16'($urandom_range(16'h0400, 16'hFFFF));
        else t.addr = 16'($urandom_range(0, 7) * 4);
        if (t.size == HSIZE_BYTE) t.addr = t.addr | 16'($urandom_range(0, 3));
        else if (t.size == HSIZE_HWORD) t.addr = t.addr | 16'($urandom_range(0, 1) * 2);
        if ($urandom_range(0, 19) == 0) t.addr = t.addr | 16'($urandom_range(1, 3));
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle(input int p);
        hsel[p] = 1'b0; htrans[p] = HTRANS_IDLE; hwrite[p] = 1'b0; hsize[p] = HSIZE_WORD;
        haddr[p] = 16'h0; hburst[p] = HBURST_SINGLE; hprot[p] = 4'h0; hwdata[p] = 32'h0;
        stall[p] = 1'b0;
    endtask

    // Pipelined master: address phase of one transfer overlaps the data phase of the previous.
    task automatic run_port(input int p);
        tx_t         ap;
        logic        ap_v, stall_done, dpv, dp_err, dp_wr, dp_kv, rdy, rsp;
        logic [31:0] dp_kexp, dp_wdata, rd, exp;
        int          dc, cyc;
        ap_v = 1'b0; stall_done = 1'b0; dpv = 1'b0; dp_err = 1'b0; dp_wr = 1'b0; dp_kv = 1'b0;
        dp_kexp = '0; dp_wdata = '0; dc = 0; cyc = 0;
        ap = mk(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 16'h0, 32'h0, 1'b0, 32'h0);
        while ((txq.size() > 0 || ap_v || dpv) && cyc < 5000) begin
            cyc++;
            if (!ap_v && txq.size() > 0) begin
                ap = txq.pop_front();
                ap_v = 1'b1;
                stall_done = 1'b0;
            end
            if (ap_v) begin
                hsel[p] = ap.sel; htrans[p] = ap.trans; hwrite[p] = ap.write;
                hsize[p] = ap.size; haddr[p] = ap.addr;
            end else begin
                hsel[p] = 1'b0; htrans[p] = HTRANS_IDLE;
            end
            hburst[p] = 3'($urandom_range(0, 7));
            hprot[p]  = 4'($urandom_range(0, 15));
            stall[p]  = ap_v && ap.stall && !stall_done && !dpv;
            hwdata[p] = dpv ? dp_wdata : $urandom();
            @(negedge clk);
            rdy = hreadyout[p]; rsp = hresp[p]; rd = hrdata[p];
            if (dpv) begin
                check($sformatf("p%0d_resp", p), 32'(rsp), 32'(dp_err));
                if (rdy) begin
                    check($sformatf("p%0d_lat", p), 32'(dc), 32'(dp_err ? 1 : ws_of(p)));
                    if (!dp_err && !dp_wr) begin
                        exp = exp_q.pop_front();
                        check($sformatf("p%0d_rdata", p), rd, exp);
                        if (dp_kv) check($sformatf("p%0d_known", p), rd, dp_kexp);
                        last_rd[p] = exp;
                    end else begin
                        check($sformatf("p%0d_hold", p), rd, last_rd[p]);
                    end
                    dpv = 1'b0;
                end else begin
                    check($sformatf("p%0d_hold", p), rd, last_rd[p]);
                    dc++;
                    if (dc > 17) begin
                        check($sformatf("p%0d_lat", p), 32'(dc), 32'(dp_err ? 1 : ws_of(p)));
                        dpv = 1'b0;
                    end
                end
            end else begin
                check($sformatf("p%0d_idle_rdy", p), 32'(rdy), 32'h1);
                check($sformatf("p%0d_idle_resp", p), 32'(rsp), 32'(HRESP_OKAY));
                check($sformatf("p%0d_hold", p), rd, last_rd[p]);
            end
            if (ap_v && rdy && !stall[p]) begin
                if (ap.sel && ap.trans[1]) begin
                    dpv = 1'b1; dc = 0;
                    dp_err = is_err(ap.size, ap.addr);
                    dp_wr = ap.write; dp_wdata = ap.wdata; dp_kv = ap.kv; dp_kexp = ap.kexp;
                    if (!dp_err) begin
                        if (ap.write) model_write(p, ap.size, ap.addr, ap.wdata);
                        else exp_q.push_back(ref_mem[p][int'(ap.addr) / 4]);
                    end
                end
                ap_v = 1'b0;
            end
            if (stall[p]) stall_done = 1'b1;
            @(posedge clk);
            #1;
        end
        drive_idle(p);
        check($sformatf("p%0d_budget", p), 32'(cyc >= 5000), 32'h0);
    endtask

    task automatic preload(input int p);
        for (int w = 0; w < 256; w++) begin
            txq.push_back(mk(1'b1, (w % 2 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD,
                             16'(w * 4), $urandom(), 1'b0, 32'h0));
        end
        run_port(p);
    endtask

    task automatic random_traffic(input int p, input int n);
        for (int i = 0; i < n; i++) txq.push_back(rand_tx());
        run_port(p);
    endtask

    // Reset lands while a write to addr is still in its data phase; the write must be lost.
    task automatic reset_mid_write(input int p, input logic [15:0] addr);
        logic [31:0] old;
        old = ref_mem[p][int'(addr) / 4];
        hsel[p] = 1'b1; htrans[p] = HTRANS_NONSEQ; hwrite[p] = 1'b1; hsize[p] = HSIZE_WORD;
        haddr[p] = addr; hwdata[p] = $urandom();
        @(negedge clk);
        check($sformatf("p%0d_rst_pre_rdy", p), 32'(hreadyout[p]), 32'h1);
        @(posedge clk);
        #1;
        hsel[p] = 1'b0; htrans[p] = HTRANS_IDLE; hwdata[p] = ~old;
        hreset = 1'b1;
        @(negedge clk);
        check($sformatf("p%0d_rst_mid_rdy", p), 32'(hreadyout[p]), 32'(ws_of(p) == 0));
        @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        check($sformatf("p%0d_rst_rdy", p), 32'(hreadyout[p]), 32'h1);
        check($sformatf("p%0d_rst_resp", p), 32'(hresp[p]), 32'(HRESP_OKAY));
        check($sformatf("p%0d_rst_rdata", p), hrdata[p], 32'h0);
        last_rd[p] = 32'h0;
        @(posedge clk);
        #1;
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0, 1'b1, old));
        run_port(p);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tx_t t;
        n_checks = 0; n_pass = 0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        drive_idle(0); drive_idle(1);
        hreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("p%0d_reset_rdy", p), 32'(hreadyout[p]), 32'h1);
            check($sformatf("p%0d_reset_resp", p), 32'(hresp[p]), 32'(HRESP_OKAY));
            check($sformatf("p%0d_reset_rdata", p), hrdata[p], 32'h0);
            check($sformatf("p%0d_reset_state", p), 32'(dbg[p]), 32'(SLV_IDLE));
        end
        @(posedge clk);
        #1;

        // Zero-wait instance.
        preload(0);
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'h11223344, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0022, 32'h00AA0000, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0020, 32'h0, 1'b1, 32'h11AA3344));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0400, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HWORD, 16'h0031, 32'h55667788, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0030, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 16'h0010, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, 1'b0, 32'h0));
        t = mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF);
        t.stall = 1'b1;
        txq.push_back(t);
        run_port(0);
        random_traffic(0, 300);
        reset_mid_write(0, 16'h0044);

        // Two-wait instance.
        preload(1);
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'h11223344, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0022, 32'h00AA0000, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0020, 32'h0, 1'b1, 32'h11AA3344));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0400, 32'h0, 1'b0, 32'h0));
        txq.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0002, 32'h12345678, 1'b0, 32'h0));
        run_port(1);
        random_traffic(1, 300);
        reset_mid_write(1, 16'h0040);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
